adc_hyst_freq_meter: RTL

Parametrised successor to the ADC-MSB frequency divider. It captures CH channels of W-bit offset-binary ADC samples on CLK_250M and squares each channel with a programmable hysteresis comparator, replacing the raw MSB slicer. It then counts rising edges per channel over a fixed gate window. Results feed the frequency readout; square_out can also drive DAC bit lines directly.

---
 rtl/adc_hyst_freq_meter_pkg.sv | 24 ++
 rtl/adc_hyst_freq_meter_cmp.sv | 52 +++++
 rtl/adc_hyst_freq_meter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/adc_hyst_freq_meter_pkg.sv
// Shared types and helpers for the hysteresis ADC frequency meter.
// Holds the measurement FSM encoding and channel/gate sizing helpers.
package adc_meas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        GATE   = 2'd2,
        REPORT = 2'd3
    } meas_state_e;

    localparam int GATE_CYCLES_DEFAULT = 250000;
    localparam int GATE_CNT_W_DEFAULT  = $clog2(GATE_CYCLES_DEFAULT);

    // Gate counter width; never narrower than one bit.
    function automatic int gate_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic int ch_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/adc_hyst_freq_meter_cmp.sv
// Single-channel sample register, hysteresis comparator and rising-edge detector.
// square output lags the raw sample by two clocks.
module adc_hyst_cmp
    import adc_meas_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK_250M,
    input  logic         RST_n,
    input  logic [W-1:0] sample,
    input  logic [W-1:0] thr_hi,
    input  logic [W-1:0] thr_lo,
    output logic         sq,
    output logic         rise
);

    logic [W-1:0] s1_r;
    logic         sq_r;
    logic         sq_d_r;
    logic         sq_s;

    // Comparator decision; a collapsed or inverted window degrades to a plain slicer.
    always_comb begin
        sq_s = sq_r;
        if (thr_lo >= thr_hi) begin
            sq_s = (s1_r >= thr_hi);
        end else if (s1_r >= thr_hi) begin
            sq_s = 1'b1;
        end else if (s1_r <= thr_lo) begin
            sq_s = 1'b0;
        end else begin
            sq_s = sq_r;
        end
    end

    // Sample, comparator and edge-history registers.
    always_ff @(posedge CLK_250M) begin
        if (!RST_n) begin
            s1_r   <= '0;
            sq_r   <= 1'b0;
            sq_d_r <= 1'b0;
        end else begin
            s1_r   <= sample;
            sq_r   <= sq_s;
            sq_d_r <= sq_r;
        end
    end

    assign sq   = sq_r;
    assign rise = sq_r & ~sq_d_r;

endmodule

// File: rtl/adc_hyst_freq_meter.sv
// Multi-channel ADC frequency meter: hysteresis squaring per channel and
// rising-edge counting over a fixed gate window, with one-shot or continuous reporting.
module adc_hyst_freq_meter
    import adc_meas_pkg::*;
#(
    parameter int CH          = 2,
    parameter int W           = 8,
    parameter int GATE_CYCLES = 250000,
    parameter int CW          = 20
) (
    input  logic            CLK_250M,
    input  logic            RST_n,
    input  logic [CH*W-1:0] adc_data,
    input  logic [W-1:0]    thr_hi,
    input  logic [W-1:0]    thr_lo,
    input  logic            start,
    input  logic            cont_mode,
    output logic [CH-1:0]   square_out,
    output logic [CH*CW-1:0] freq_count,
    output logic            count_valid,
    output logic [CH-1:0]   overflow,
    output logic            busy
);

    localparam int             GCW       = gate_cnt_width(GATE_CYCLES);
    localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX   = {CW{1'b1}};

    meas_state_e      state_r;
    meas_state_e      state_s;
    logic [W-1:0]     thr_hi_r;
    logic [W-1:0]     thr_lo_r;
    logic [GCW-1:0]   gate_cnt_r;
    logic [CH*CW-1:0] cnt_r;
    logic [CH*CW-1:0] cnt_nxt_s;
    logic [CH-1:0]    ovf_r;
    logic [CH-1:0]    ovf_nxt_s;
    logic [CH-1:0]    sq_s;
    logic [CH-1:0]    rise_s;
    logic [CH*CW-1:0] freq_count_r;
    logic [CH-1:0]    overflow_r;
    logic             count_valid_r;
    logic             busy_r;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        adc_hyst_cmp #(.W(W)) u_cmp (
            .CLK_250M (CLK_250M),
            .RST_n    (RST_n),
            .sample   (adc_data[ch_lsb(c, W) +: W]),
            .thr_hi   (thr_hi_r),
            .thr_lo   (thr_lo_r),
            .sq       (sq_s[c]),
            .rise     (rise_s[c])
        );
    end

    // Measurement sequencing; a start outside IDLE is simply not looked at.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = start ? ARM : IDLE;
            ARM:     state_s = GATE;
            GATE:    state_s = (gate_cnt_r == GATE_LAST) ? REPORT : GATE;
            REPORT:  state_s = cont_mode ? ARM : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Saturating per-channel edge counters, advanced only inside the gate.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = ovf_r;
        for (int c = 0; c < CH; c++) begin
            if ((state_r == GATE) && rise_s[c]) begin
                if (cnt_r[ch_lsb(c, CW) +: CW] == CNT_MAX) begin
                    ovf_nxt_s[c] = 1'b1;
                end else begin
                    cnt_nxt_s[ch_lsb(c, CW) +: CW] = cnt_r[ch_lsb(c, CW) +: CW] + CW'(1);
                end
            end else begin
                ovf_nxt_s[c] = ovf_r[c];
            end
        end
    end

    // FSM, threshold latch, gate counter and edge counters.
    always_ff @(posedge CLK_250M) begin
        if (!RST_n) begin
            state_r    <= IDLE;
            thr_hi_r   <= '0;
            thr_lo_r   <= '0;
            gate_cnt_r <= '0;
            cnt_r      <= '0;
            ovf_r      <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == ARM) begin
                thr_hi_r   <= thr_hi;
                thr_lo_r   <= thr_lo;
                gate_cnt_r <= '0;
                cnt_r      <= '0;
                ovf_r      <= '0;
            end else begin
                gate_cnt_r <= (state_r == GATE) ? gate_cnt_r + GCW'(1) : gate_cnt_r;
                cnt_r      <= cnt_nxt_s;
                ovf_r      <= ovf_nxt_s;
            end
        end
    end

    // Report registers load on the last gate cycle so they are valid throughout REPORT.
    always_ff @(posedge CLK_250M) begin
        if (!RST_n) begin
            freq_count_r  <= '0;
            overflow_r    <= '0;
            count_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            count_valid_r <= (state_s == REPORT);
            busy_r        <= (state_s != IDLE);
            if ((state_r == GATE) && (state_s == REPORT)) begin
                freq_count_r <= cnt_nxt_s;
                overflow_r   <= ovf_nxt_s;
            end else begin
                freq_count_r <= freq_count_r;
                overflow_r   <= overflow_r;
            end
        end
    end

    assign square_out  = sq_s;
    assign freq_count  = freq_count_r;
    assign overflow    = overflow_r;
    assign count_valid = count_valid_r;
    assign busy        = busy_r;

endmodule
